// File: rtl/ddr4_addr_lane_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddr4_addr_lane_tx_ctrl : DDR4 address-pin gearbox driver + delay stepper |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module ddr4_addr_lane_tx_ctrl #(
   parameter int LAT_MAX  = 3,
   parameter int INIT_TAP = 1,
   parameter int TAP_MAX  = 127,
   parameter int MOVE_GAP = 4
) (
   input  logic       FAB_CLK,
   input  logic       TX_SYNC_RST,
   input  logic [1:0] CA_PHASE,
   input  logic       CA_OE,
   input  logic [1:0] ADDR_LAT,
   output logic [3:0] TX_DATA_0,
   output logic [3:0] OE_DATA_0,
   input  logic       DLY_REQ,
   input  logic       DLY_LOAD,
   input  logic       DLY_DIR,
   input  logic [7:0] DLY_STEPS,
   output logic       DLY_BUSY,
   output logic       DLY_DONE,
   output logic       DLY_ERR,
   output logic [7:0] DLY_TAP,
   output logic       DELAY_LINE_MOVE_0,
   output logic       DELAY_LINE_DIRECTION_0,
   output logic       DELAY_LINE_LOAD_0,
   input  logic       DELAY_LINE_OUT_OF_RANGE_0
);

   localparam int                 c_gap_w    = (MOVE_GAP > 2) ? $clog2(MOVE_GAP) : 1;
   localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(MOVE_GAP - 2);
   localparam logic [7:0]         c_init_tap = 8'(INIT_TAP);
   localparam logic [7:0]         c_tap_max  = 8'(TAP_MAX);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SETUP = 3'd2,
      S_MOVE  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // Stage 0 is pipe[0]; each entry is {oe, phase1, phase0}
   logic [LAT_MAX:0][2:0] pipe_q, pipe_d;
   logic [2:0]            pipe_sel;
   logic [3:0]            tx_data_q, tx_data_d;
   logic [3:0]            oe_data_q, oe_data_d;

   state_t               state_q, state_d;
   logic                 dir_lat_q, dir_lat_d;
   logic [7:0]           steps_q, steps_d;
   logic [7:0]           tap_q, tap_d;
   logic [c_gap_w-1:0]   gap_cnt_q, gap_cnt_d;
   logic                 move_q, move_d;
   logic                 load_q, load_d;
   logic                 dir_out_q, dir_out_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 oor_q, oor_d;
   logic                 at_limit;
   logic                 step_err;
   state_t               step_next;

   always_comb begin
      pipe_d[0] = {CA_OE, CA_PHASE};
      for (int k = 1; k <= LAT_MAX; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
      pipe_sel = pipe_q[LAT_MAX];
      for (int k = 0; k < LAT_MAX; k++) begin
         if (int'(ADDR_LAT) == k) begin
            pipe_sel = pipe_q[k];
         end
      end
      tx_data_d = {pipe_sel[1], pipe_sel[1], pipe_sel[0], pipe_sel[0]};
      oe_data_d = {4{pipe_sel[2]}};
   end

   // Step decision shared by SETUP and the final GAP cycle so MOVEs stay MOVE_GAP apart
   always_comb begin
      at_limit  = dir_lat_q ? (tap_q == c_tap_max) : (tap_q == 8'd0);
      step_err  = (steps_q != 8'd0) && at_limit;
      step_next = ((steps_q == 8'd0) || at_limit) ? S_DONE : S_MOVE;
   end

   always_comb begin
      state_d   = state_q;
      dir_lat_d = dir_lat_q;
      steps_d   = steps_q;
      tap_d     = tap_q;
      gap_cnt_d = gap_cnt_q;
      dir_out_d = dir_out_q;
      busy_d    = busy_q;
      err_d     = err_q;
      move_d    = 1'b0;
      load_d    = 1'b0;
      done_d    = 1'b0;
      oor_d     = DELAY_LINE_OUT_OF_RANGE_0;
      case (state_q)
         S_IDLE: begin
            if (DLY_REQ) begin
               dir_lat_d = DLY_DIR;
               dir_out_d = DLY_DIR;
               steps_d   = DLY_STEPS;
               err_d     = 1'b0;
               busy_d    = 1'b1;
               state_d   = DLY_LOAD ? S_LOAD : S_SETUP;
            end
         end
         S_LOAD: begin
            load_d  = 1'b1;
            tap_d   = c_init_tap;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            dir_out_d = dir_lat_q;
            state_d   = step_next;
            if (step_err) begin
               err_d = 1'b1;
            end
         end
         S_MOVE: begin
            move_d    = 1'b1;
            tap_d     = dir_lat_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
            steps_d   = steps_q - 8'd1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
         end
         S_GAP: begin
            if (oor_q) begin
               tap_d   = dir_lat_q ? (tap_q - 8'd1) : (tap_q + 8'd1);
               err_d   = 1'b1;
               state_d = S_DONE;
            end else if (gap_cnt_q == c_gap_last) begin
               state_d = step_next;
               if (step_err) begin
                  err_d = 1'b1;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge FAB_CLK) begin
      if (TX_SYNC_RST) begin
         pipe_q    <= '0;
         tx_data_q <= '0;
         oe_data_q <= '0;
         state_q   <= S_IDLE;
         dir_lat_q <= 1'b0;
         steps_q   <= '0;
         tap_q     <= c_init_tap;
         gap_cnt_q <= '0;
         move_q    <= 1'b0;
         load_q    <= 1'b0;
         dir_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         oor_q     <= 1'b0;
      end else begin
         pipe_q    <= pipe_d;
         tx_data_q <= tx_data_d;
         oe_data_q <= oe_data_d;
         state_q   <= state_d;
         dir_lat_q <= dir_lat_d;
         steps_q   <= steps_d;
         tap_q     <= tap_d;
         gap_cnt_q <= gap_cnt_d;
         move_q    <= move_d;
         load_q    <= load_d;
         dir_out_q <= dir_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         oor_q     <= oor_d;
      end
   end

   assign TX_DATA_0              = tx_data_q;
   assign OE_DATA_0              = oe_data_q;
   assign DLY_BUSY               = busy_q;
   assign DLY_DONE               = done_q;
   assign DLY_ERR                = err_q;
   assign DLY_TAP                = tap_q;
   assign DELAY_LINE_MOVE_0      = move_q;
   assign DELAY_LINE_DIRECTION_0 = dir_out_q;
   assign DELAY_LINE_LOAD_0      = load_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_addr_lane_tx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ddr4_addr_lane_tx_ctrl : directed bench for ddr4_addr_lane_tx_ctrl     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_ddr4_addr_lane_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] ca_phase;
   logic       ca_oe;
   logic [1:0] addr_lat;
   logic [3:0] tx_data;
   logic [3:0] oe_data;
   logic       dly_req;
   logic       dly_load;
   logic       dly_dir;
   logic [7:0] dly_steps;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] tap;
   logic       mv;
   logic       dr;
   logic       ld;
   logic       oor;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ld_tot   = 0;
   int done_tot = 0;
   int mv_times[$];
   logic mv_dirs[$];

   ddr4_addr_lane_tx_ctrl #(
      .LAT_MAX (3),
      .INIT_TAP(1),
      .TAP_MAX (127),
      .MOVE_GAP(4)
   ) dut (
      .FAB_CLK                  (clk),
      .TX_SYNC_RST              (rst),
      .CA_PHASE                 (ca_phase),
      .CA_OE                    (ca_oe),
      .ADDR_LAT                 (addr_lat),
      .TX_DATA_0                (tx_data),
      .OE_DATA_0                (oe_data),
      .DLY_REQ                  (dly_req),
      .DLY_LOAD                 (dly_load),
      .DLY_DIR                  (dly_dir),
      .DLY_STEPS                (dly_steps),
      .DLY_BUSY                 (busy),
      .DLY_DONE                 (done),
      .DLY_ERR                  (err),
      .DLY_TAP                  (tap),
      .DELAY_LINE_MOVE_0        (mv),
      .DELAY_LINE_DIRECTION_0   (dr),
      .DELAY_LINE_LOAD_0        (ld),
      .DELAY_LINE_OUT_OF_RANGE_0(oor)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mv === 1'b1) begin
         mv_times.push_back(cyc);
         mv_dirs.push_back(dr);
      end
      if (ld === 1'b1) ld_tot++;
      if (done === 1'b1) done_tot++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic req(input logic load, input logic dir, input logic [7:0] steps, output int acc);
      dly_req   = 1'b1;
      dly_load  = load;
      dly_dir   = dir;
      dly_steps = steps;
      step(1);
      acc     = cyc;
      dly_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, output int at);
      at = -1;
      for (int i = 0; i < 200; i++) begin
         step(1);
         if (done === 1'b1) begin
            at = cyc;
            break;
         end
      end
      chk(tag, 32'(at >= 0), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tx"},   32'(tx_data), 32'd0);
      chk({tag, "_oe"},   32'(oe_data), 32'd0);
      chk({tag, "_busy"}, 32'(busy),    32'd0);
      chk({tag, "_done"}, 32'(done),    32'd0);
      chk({tag, "_err"},  32'(err),     32'd0);
      chk({tag, "_tap"},  32'(tap),     32'd1);
      chk({tag, "_move"}, 32'(mv),      32'd0);
      chk({tag, "_load"}, 32'(ld),      32'd0);
      chk({tag, "_dir"},  32'(dr),      32'd0);
   endtask

   initial begin
      int acc, at, mb, lb, db, nb, nbad, seen, first;
      rst = 1'b1; ca_phase = 2'b00; ca_oe = 1'b0; addr_lat = 2'd0;
      dly_req = 1'b0; dly_load = 1'b0; dly_dir = 1'b0; dly_steps = 8'd0; oor = 1'b0;
      step(3);
      chk_reset("rst");
      rst = 1'b0;
      step(2);

      // Datapath, ADDR_LAT=2: one-cycle pulse appears 3 edges after capture
      addr_lat = 2'd2; ca_oe = 1'b1; ca_phase = 2'b10;
      step(1);
      ca_oe = 1'b0; ca_phase = 2'b00;
      chk("lat2_c1_tx", 32'(tx_data), 32'd0);
      step(1);
      chk("lat2_c2_tx", 32'(tx_data), 32'd0);
      step(1);
      chk("lat2_c3_oe", 32'(oe_data), 32'd0);
      step(1);
      chk("lat2_tx", 32'(tx_data), 32'b1100);
      chk("lat2_oe", 32'(oe_data), 32'b1111);
      step(1);
      chk("lat2_after_tx", 32'(tx_data), 32'd0);
      chk("lat2_after_oe", 32'(oe_data), 32'd0);

      // Datapath, ADDR_LAT=0
      step(3);
      addr_lat = 2'd0; ca_oe = 1'b1; ca_phase = 2'b01;
      step(1);
      ca_oe = 1'b0; ca_phase = 2'b00;
      chk("lat0_early_tx", 32'(tx_data), 32'd0);
      step(1);
      chk("lat0_tx", 32'(tx_data), 32'b0011);
      chk("lat0_oe", 32'(oe_data), 32'b1111);
      step(1);
      chk("lat0_after_oe", 32'(oe_data), 32'd0);

      // LOAD + 5 up-steps
      mb = mv_times.size(); lb = ld_tot; db = done_tot;
      req(1'b1, 1'b1, 8'd5, acc);
      chk("t2_busy", 32'(busy), 32'd1);
      wait_done("t2_done_seen", at);
      chk("t2_done_lat", 32'(at - acc), 32'd23);
      chk("t2_busy_at_done", 32'(busy), 32'd0);
      chk("t2_tap", 32'(tap), 32'd6);
      chk("t2_err", 32'(err), 32'd0);
      step(1);
      chk("t2_done_1cyc", 32'(done), 32'd0);
      chk("t2_done_cnt", 32'(done_tot - db), 32'd1);
      chk("t2_loads", 32'(ld_tot - lb), 32'd1);
      chk("t2_moves", 32'(mv_times.size() - mb), 32'd5);
      first = (mv_times.size() > mb) ? (mv_times[mb] - acc) : -1;
      chk("t2_first_move", 32'(first), 32'd3);
      nbad = 0;
      for (int k = mb + 1; k < mv_times.size(); k++)
         if (mv_times[k] - mv_times[k-1] != 4) nbad++;
      for (int k = mb; k < mv_dirs.size(); k++)
         if (mv_dirs[k] !== 1'b1) nbad++;
      chk("t2_spacing_dir", 32'(nbad), 32'd0);

      // LOAD to tap 1, 3 down-steps: one MOVE then range abort at tap 0
      mb = mv_times.size(); lb = ld_tot;
      req(1'b1, 1'b0, 8'd3, acc);
      wait_done("t3_done_seen", at);
      chk("t3_done_lat", 32'(at - acc), 32'd7);
      chk("t3_tap", 32'(tap), 32'd0);
      chk("t3_err", 32'(err), 32'd1);
      step(3);
      chk("t3_moves", 32'(mv_times.size() - mb), 32'd1);
      chk("t3_loads", 32'(ld_tot - lb), 32'd1);
      chk("t3_err_sticky", 32'(err), 32'd1);

      // Bring tap to 10, then OUT_OF_RANGE after the 2nd of 4 up-steps
      req(1'b1, 1'b1, 8'd9, acc);
      wait_done("t4a_done_seen", at);
      chk("t4a_done_lat", 32'(at - acc), 32'd39);
      chk("t4a_tap", 32'(tap), 32'd10);
      chk("t4a_err_cleared", 32'(err), 32'd0);
      step(2);
      mb = mv_times.size();
      req(1'b0, 1'b1, 8'd4, acc);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (mv === 1'b1) begin
            seen++;
            if (seen == 2) break;
         end
      end
      chk("t4_second_move_seen", 32'(seen), 32'd2);
      oor = 1'b1;
      wait_done("t4_done_seen", at);
      oor = 1'b0;
      chk("t4_done_lat", 32'(at - acc), 32'd9);
      chk("t4_tap", 32'(tap), 32'd11);
      chk("t4_err", 32'(err), 32'd1);
      step(6);
      chk("t4_moves", 32'(mv_times.size() - mb), 32'd2);

      // STEPS=0 without LOAD; second request while busy ignored
      mb = mv_times.size(); lb = ld_tot; db = done_tot;
      dly_req = 1'b1; dly_load = 1'b0; dly_dir = 1'b1; dly_steps = 8'd0;
      step(1);
      chk("t5_busy", 32'(busy), 32'd1);
      dly_load = 1'b1; dly_steps = 8'd7;
      step(1);
      chk("t5_done_early", 32'(done), 32'd0);
      step(1);
      dly_req = 1'b0;
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_busy_clr", 32'(busy), 32'd0);
      step(4);
      chk("t5_moves", 32'(mv_times.size() - mb), 32'd0);
      chk("t5_loads", 32'(ld_tot - lb), 32'd0);
      chk("t5_done_cnt", 32'(done_tot - db), 32'd1);
      chk("t5_busy_idle", 32'(busy), 32'd0);
      chk("t5_tap", 32'(tap), 32'd11);
      chk("t5_err", 32'(err), 32'd0);

      // Reset in the middle of a stepping sequence
      req(1'b0, 1'b1, 8'd3, acc);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (mv === 1'b1) begin
            seen = 1;
            break;
         end
      end
      chk("t6_move_seen", 32'(seen), 32'd1);
      step(1);
      rst = 1'b1;
      step(1);
      chk_reset("t6_rst");
      rst = 1'b0;
      nb = mv_times.size();
      step(8);
      chk("t6_no_inflight", 32'(mv_times.size() - nb), 32'd0);
      chk("t6_idle_busy", 32'(busy), 32'd0);
      req(1'b0, 1'b1, 8'd2, acc);
      wait_done("t6_done_seen", at);
      chk("t6_done_lat", 32'(at - acc), 32'd10);
      chk("t6_tap", 32'(tap), 32'd3);
      chk("t6_err", 32'(err), 32'd0);
      step(2);
      chk("t6_moves", 32'(mv_times.size() - nb), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
